// File: rtl/konwersja_pkg.sv
// Shared types for the ZM <-> U2 code converter.
// The MSB-only pattern is both ZM negative zero and the U2 most-negative value.
package konwersja_pkg;

  typedef enum logic {
    MODE_ZM2U2 = 1'b0,
    MODE_U22ZM = 1'b1
  } conv_mode_t;

  localparam int MAX_BITS = 64;

  function automatic logic [MAX_BITS-1:0] msb_only(input int bits);
    logic [MAX_BITS-1:0] p;
    p = '0;
    p[bits-1] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/konwersja_core.sv
// Combinational ZM <-> U2 conversion of one operand.
// The MSB-only code has no counterpart in the target code and is flagged.
module konwersja_core
  import konwersja_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] arg,
  input  conv_mode_t      mode,
  output logic [BITS-1:0] result,
  output logic            error
);

  localparam logic [BITS-1:0] NEG_PAT = BITS'(msb_only(BITS));

  logic            s;
  logic            m_zero;
  logic [BITS-1:0] neg_mag;
  logic [BITS-1:0] neg_arg;

  assign s       = arg[BITS-1];
  assign m_zero  = (arg == NEG_PAT);
  assign neg_mag = ~{1'b0, arg[BITS-2:0]} + BITS'(1);
  assign neg_arg = ~arg + BITS'(1);

  always_comb begin
    result = arg;
    error  = 1'b0;
    unique case (1'b1)
      !s: ;
      s && m_zero: begin
        result = '0;
        error  = 1'b1;
      end
      s && !m_zero && (mode == MODE_ZM2U2):
        result = neg_mag;
      s && !m_zero && (mode == MODE_U22ZM):
        result = {1'b1, neg_arg[BITS-2:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/konwersja_pipe.sv
// Two-stage valid/ready pipeline around konwersja_core.
// Keeps a saturating count of errored results handed downstream.
module konwersja_pipe
  import konwersja_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BITS-1:0]  i_arg_A,
  input  logic             i_mode,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef struct packed {
    logic [BITS-1:0] arg;
    conv_mode_t      mode;
  } s1_t;

  typedef struct packed {
    logic [BITS-1:0] res;
    logic            err;
  } s2_t;

  s1_t  s1_q;
  s2_t  s2_q;
  s2_t  s2_d;
  logic s1_valid;
  logic s2_valid;
  logic s1_en;
  logic s2_en;
  logic out_xfer;

  assign s2_en    = ~s2_valid | i_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign o_ready  = s1_en;
  assign out_xfer = s2_valid & i_ready;

  konwersja_core #(.BITS(BITS)) u_core (
    .arg    (s1_q.arg),
    .mode   (s1_q.mode),
    .result (s2_d.res),
    .error  (s2_d.err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_q.arg  <= i_arg_A;
        s1_q.mode <= conv_mode_t'(i_mode);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  // clear has priority over a same-cycle errored delivery
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (i_clear) begin
      o_err_cnt <= '0;
    end else if (out_xfer && s2_q.err && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end

  assign o_valid  = s2_valid;
  assign o_result = s2_q.res;
  assign o_error  = s2_q.err;

endmodule

// File: tb/tb_konwersja_pipe.sv
// Scoreboard bench for konwersja_pipe (BITS=8).
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_konwersja_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] arg = '0;
  logic       mode = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic       i_clear = 1'b0;
  logic       o_ready, o_error, o_valid;
  logic [7:0] o_result, cnt;
  logic       o_ready2, o_error2, o_valid2;
  logic [7:0] res2;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  konwersja_pipe #(.BITS(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_arg_A(arg), .i_mode(mode),
    .i_valid(i_valid), .o_ready(o_ready), .o_result(o_result),
    .o_error(o_error), .o_valid(o_valid), .i_ready(i_ready),
    .i_clear(i_clear), .o_err_cnt(cnt)
  );

  konwersja_pipe #(.BITS(8), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_arg_A(arg), .i_mode(mode),
    .i_valid(i_valid), .o_ready(o_ready2), .o_result(res2),
    .o_error(o_error2), .o_valid(o_valid2), .i_ready(i_ready),
    .i_clear(i_clear), .o_err_cnt(cnt2)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;
  logic held = 1'b0;
  logic [7:0] hr;
  logic he;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] zm2u2(input logic [7:0] z);
    int v;
    v = z[7] ? -int'(z[6:0]) : int'(z[6:0]);
    return 8'(v);
  endfunction

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [7:0] a, input logic m,
                      input logic [7:0] r, input logic e);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    i_valid = 1'b1;
    arg = a;
    mode = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      if (acc) q.push_back('{r: r, e: e});
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      exp_cnt2 = 0;
      held = 1'b0;
    end else begin
      chk("err_cnt", cnt, exp_cnt);
      chk("err_cnt_w2", cnt2, exp_cnt2);
      if (held) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_res", o_result, hr);
        chk("hold_err", o_error, he);
      end
      held = 1'b0;
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", o_valid, 0);
        end else begin
          e = q.pop_front();
          chk("result", o_result, e.r);
          chk("error", o_error, e.e);
          chk("result_w2", res2, e.r);
          chk("error_w2", o_error2, e.e);
          if (e.e) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
          end
        end
      end else if (o_valid) begin
        held = 1'b1;
        hr = o_result;
        he = o_error;
      end
      if (i_clear) begin
        exp_cnt = 0;
        exp_cnt2 = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] u;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_error", o_error, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_ready_w2", o_ready2, 1);
    rst_n = 1'b1;
    chk("post_rst_ready", o_ready, 1);

    send(8'h85, 1'b0, 8'hFB, 1'b0);
    chk("lat_edge_n", o_valid, 0);
    send(8'h05, 1'b0, 8'h05, 1'b0);
    chk("lat_edge_n1", o_valid, 1);
    chk("lat_res", o_result, 8'hFB);
    send(8'hFF, 1'b0, 8'h81, 1'b0);
    chk("stream_b2b", o_valid, 1);
    idle(3);

    send(8'hFB, 1'b1, 8'h85, 1'b0);
    send(8'h81, 1'b1, 8'hFF, 1'b0);
    send(8'h7F, 1'b1, 8'h7F, 1'b0);
    idle(3);

    send(8'h80, 1'b0, 8'h00, 1'b1);
    send(8'h80, 1'b1, 8'h00, 1'b1);
    idle(3);
    chk("err_cnt_two", cnt, 2);

    i_ready = 1'b0;
    send(8'h01, 1'b0, 8'h01, 1'b0);
    send(8'h02, 1'b0, 8'h02, 1'b0);
    fork
      begin
        send(8'h03, 1'b0, 8'h03, 1'b0);
        send(8'h04, 1'b0, 8'h04, 1'b0);
      end
      begin
        repeat (2) begin
          @(negedge clk);
          chk("bp_ready", o_ready, 0);
          chk("bp_ready_w2", o_ready2, 0);
          chk("bp_hold", o_result, 8'h01);
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("bp_no_gap", o_valid, 1);
        end
      end
    join
    idle(3);

    for (int c = 0; c < 256; c++) begin
      if (c != 8'h80) begin
        u = zm2u2(8'(c));
        send(8'(c), 1'b0, u, 1'b0);
        send(u, 1'b1, 8'(c), 1'b0);
      end
    end
    idle(3);

    for (int k = 0; k < 5; k++) send(8'h80, 1'(k), 8'h00, 1'b1);
    idle(3);
    chk("cnt_w2_sat", cnt2, 3);
    chk("cnt_w8", cnt, 7);

    i_ready = 1'b0;
    send(8'h80, 1'b1, 8'h00, 1'b1);
    idle(1);
    i_ready = 1'b1;
    i_clear = 1'b1;
    idle(1);
    i_clear = 1'b0;
    chk("clear_wins", cnt, 0);
    chk("clear_wins_w2", cnt2, 0);

    send(8'h80, 1'b0, 8'h00, 1'b1);
    idle(3);
    chk("pre_rst_cnt", cnt, 1);
    i_ready = 1'b0;
    send(8'h11, 1'b0, 8'h11, 1'b0);
    send(8'h22, 1'b0, 8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_ready", o_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    send(8'h83, 1'b0, 8'hFD, 1'b0);
    chk("rst_lat_n", o_valid, 0);
    idle(1);
    chk("rst_lat_n1", o_valid, 1);
    chk("rst_lat_res", o_result, 8'hFD);
    idle(3);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/konwersja_pipe.md
# konwersja_pipe

Pipelined, parametrised bidirectional code converter between sign-magnitude (ZM) and two's complement (U2) for the synchronous arithmetic unit. It sits between the operand source and the ALU datapath. It converts one operand per cycle in either direction, selected per transaction, with valid/ready flow control on both sides. It flags unrepresentable codes and keeps a saturating error count for the unit's status logic.

## Interface
- BITS, 32, operand width; minimum 2.
- CNT_W, 8, width of the error counter.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_arg_A  in  BITS  operand to convert.
- i_mode  in  1  0 = ZM→U2, 1 = U2→ZM (`conv_mode_t`).
- i_valid  in  1  upstream holds a valid operand.
- o_ready  out  1  block accepts an operand this cycle.
- o_result  out  BITS  converted operand.
- o_error  out  1  operand was unrepresentable in the target code.
- o_valid  out  1  o_result/o_error are valid.
- i_ready  in  1  downstream accepts the result this cycle.
- i_clear  in  1  synchronous clear of o_err_cnt.
- o_err_cnt  out  CNT_W  saturating count of errored results delivered.

## Operation
- **Conversion rules.** Let `s` = i_arg_A[BITS-1] and `m` = i_arg_A[BITS-2:0].
  - ZM→U2, s=0: result = i_arg_A, no error.
  - ZM→U2, s=1, m≠0: result = ~{1'b0,m} + 1. This is the full two's-complement negation of the magnitude.
  - ZM→U2, s=1, m=0 (negative zero): result = '0, o_error = 1.
  - U2→ZM, s=0: result = i_arg_A, no error.
  - U2→ZM, s=1, m≠0: result = {1'b1, (~i_arg_A + 1)[BITS-2:0]}.
  - U2→ZM, i_arg_A = {1'b1,'0} (most negative value): result = '0, o_error = 1.
- **Valid range.** The error-free range is −(2^(BITS-1)−1) … 2^(BITS-1)−1 in both directions. Both directions are lossless inverses over that range.
- **Pipeline.** Two register stages.
  - S1 captures {i_arg_A, i_mode}.
  - S2 holds {result, error}, computed combinationally from S1.
- **Stage enables.**
  - s2_en = ~s2_valid | i_ready.
  - s1_en = ~s1_valid | s2_en.
  - o_ready = s1_en. This is combinational from i_ready by design.
- **Transfers.**
  - Input transfer: i_valid & o_ready.
  - Output transfer: o_valid & i_ready.
  - o_valid = s2_valid.
- **Ordering.** Strict in-order delivery. No loss and no duplication under any i_ready pattern.
- **Error counter.**
  - Increments on an output transfer with o_error = 1.
  - Saturates at 2^CNT_W−1.
  - i_clear sets it to 0 next cycle and wins over a simultaneous increment.

## Timing
- **Reset values.** While i_rst_n=0: s1_valid = s2_valid = 0, o_valid = 0, o_result = '0, o_error = 0, o_err_cnt = 0.
- **o_ready during and after reset.** o_ready = 1 while in reset and from the first cycle after deassertion.
- **Latency.** An operand accepted at edge N appears on o_valid/o_result after edge N+1, provided S2 is free. The fixed latency is 2 edges.
- **Throughput.** One operand per cycle while i_ready = 1.
- **Backpressure.**
  - While o_valid & ~i_ready, o_result and o_error are held stable.
  - S1 keeps accepting until it holds a valid item. After that, o_ready = 0.
  - At most 2 items are buffered.
- **Simultaneous transfers.** With both stages full and i_ready = 1, an input transfer and an output transfer occur in the same cycle.
- **Mode.** i_mode is sampled together with i_arg_A. Mode may change every transaction with no bubble.
- **Reset mid-operation.** All in-flight items are discarded. No partial results are emitted.

## Structure
- Package `konwersja_pkg` contains:
  - `typedef enum logic {MODE_ZM2U2, MODE_U22ZM} conv_mode_t`.
  - A parametrised function or constant for the most-negative / negative-zero pattern `{1'b1, '0}`.
- Sub-module `konwersja_core` (combinational, BITS-parametrised): {arg, mode} → {result, error}. It is instantiated between S1 and S2 and is unit-testable on its own.
- Top-level `konwersja_pipe` contains the stage registers, the handshake logic and the error counter.

## Test plan
All scenarios use BITS=8 unless stated.
- **ZM→U2, continuous stream, i_ready=1.** 0x85, 0x05, 0xFF → 0xFB, 0x05, 0x81, each with error 0. Results arrive 2 edges after acceptance, back-to-back.
- **U2→ZM.** 0xFB, 0x81, 0x7F → 0x85, 0xFF, 0x7F, error 0. Round trip ZM→U2→ZM over all 255 valid codes returns the input.
- **Errors.** ZM→U2 0x80 and U2→ZM 0x80 → each gives result 0x00, error 1. o_err_cnt = 2 after both are delivered.
- **Backpressure.** Offer 0x01..0x04 every cycle with i_ready=0 for 4 cycles, then 1.
  - o_ready drops after 2 accepts.
  - Outputs are held stable while stalled.
  - Outputs appear in order 0x01..0x04 with no gaps after release.
- **Counter.** With CNT_W=2, deliver 5 errored results → o_err_cnt = 3. Then i_clear together with an errored transfer → o_err_cnt = 0.
- **Reset mid-stream.** Assert i_rst_n=0 with both stages full.
  - o_valid = 0 and o_err_cnt = 0 immediately.
  - After release, the first new operand appears after 2 edges.
